// File: rtl/spi_frame_timer.sv
// spi_frame_timer: SCK and active-low frame-select timing generator with edge strobes.
// Single clock domain; every output is a flop, sequencing OFF -> GAP -> FRAME -> GAP ...
module spi_frame_timer #(
  parameter int unsigned SCK_DIV    = 20,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned IDLE_BITS  = 16,
  parameter bit          CPOL       = 1'b0,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned BIT_W     = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             sck,
  output logic             ss_n,
  output logic             sck_lead,
  output logic             sck_trail,
  output logic             frame_start,
  output logic             frame_done,
  output logic [BIT_W-1:0] bit_idx,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  localparam int unsigned GAP_LEN = 2 * SCK_DIV * IDLE_BITS;
  localparam int unsigned HALF_N  = 2 * FRAME_BITS;
  localparam int unsigned DIV_W   = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int unsigned HALF_W  = $clog2(HALF_N);
  localparam int unsigned GAP_W   = $clog2(GAP_LEN);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_N - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_LEN - 1);
  localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_GAP,
    ST_FRAME
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              sck_q, sck_d;
  logic              ss_n_q, ss_n_d;
  logic              sck_lead_q, sck_lead_d;
  logic              sck_trail_q, sck_trail_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    half_d        = half_q;
    gap_d         = gap_q;
    sck_d         = sck_q;
    ss_n_d        = ss_n_q;
    sck_lead_d    = 1'b0;
    sck_trail_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    bit_idx_d     = bit_idx_q;
    frame_cnt_d   = frame_cnt_q;
    busy_d        = busy_q;

    unique case (state_q)
      ST_OFF: begin
        if (en) begin
          state_d = ST_GAP;
          div_d   = '0;
          half_d  = '0;
          gap_d   = '0;
          busy_d  = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (en) begin
            state_d       = ST_FRAME;
            ss_n_d        = 1'b0;
            sck_d         = CPOL;
            frame_start_d = 1'b1;
            div_d         = '0;
            half_d        = '0;
            bit_idx_d     = BIT_TOP;
          end else begin
            state_d = ST_OFF;
            busy_d  = 1'b0;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_FRAME: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          // Last half-period ends the frame: the final trailing edge and frame_done share a cycle.
          if (half_q == HALF_LAST) begin
            state_d      = ST_GAP;
            half_d       = '0;
            gap_d        = '0;
            ss_n_d       = 1'b1;
            sck_d        = CPOL;
            sck_trail_d  = 1'b1;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + CNT_W'(1);
            bit_idx_d    = BIT_TOP;
          end else begin
            half_d = half_q + HALF_W'(1);
            if (!half_q[0]) begin
              sck_d      = ~CPOL;
              sck_lead_d = 1'b1;
            end else begin
              sck_d       = CPOL;
              sck_trail_d = 1'b1;
              bit_idx_d   = bit_idx_q - BIT_W'(1);
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_OFF;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_OFF;
      div_q         <= '0;
      half_q        <= '0;
      gap_q         <= '0;
      sck_q         <= CPOL;
      ss_n_q        <= 1'b1;
      sck_lead_q    <= 1'b0;
      sck_trail_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      bit_idx_q     <= BIT_TOP;
      frame_cnt_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      half_q        <= half_d;
      gap_q         <= gap_d;
      sck_q         <= sck_d;
      ss_n_q        <= ss_n_d;
      sck_lead_q    <= sck_lead_d;
      sck_trail_q   <= sck_trail_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      bit_idx_q     <= bit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign sck         = sck_q;
  assign ss_n        = ss_n_q;
  assign sck_lead    = sck_lead_q;
  assign sck_trail   = sck_trail_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign bit_idx     = bit_idx_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_frame_timer.sv
// Bench for spi_frame_timer: default, CPOL=1 small and minimum configurations side by side.
module tb_spi_frame_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  // Instance A: defaults
  logic        rst_a, en_a, sck_a, ss_n_a, lead_a, trail_a, fs_a, fd_a, busy_a;
  logic [3:0]  bit_idx_a;
  logic [15:0] frame_cnt_a;
  // Instance B: CPOL=1, SCK_DIV=3, FRAME_BITS=4, IDLE_BITS=2
  logic        rst_b, en_b, sck_b, ss_n_b, lead_b, trail_b, fs_b, fd_b, busy_b;
  logic [1:0]  bit_idx_b;
  logic [15:0] frame_cnt_b;
  // Instance C: minimum configuration, CNT_W=2
  logic        rst_c, en_c, sck_c, ss_n_c, lead_c, trail_c, fs_c, fd_c, busy_c;
  logic [0:0]  bit_idx_c;
  logic [1:0]  frame_cnt_c;

  spi_frame_timer u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .sck(sck_a), .ss_n(ss_n_a),
    .sck_lead(lead_a), .sck_trail(trail_a), .frame_start(fs_a), .frame_done(fd_a),
    .bit_idx(bit_idx_a), .frame_cnt(frame_cnt_a), .busy(busy_a)
  );

  spi_frame_timer #(.SCK_DIV(3), .FRAME_BITS(4), .IDLE_BITS(2), .CPOL(1'b1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .sck(sck_b), .ss_n(ss_n_b),
    .sck_lead(lead_b), .sck_trail(trail_b), .frame_start(fs_b), .frame_done(fd_b),
    .bit_idx(bit_idx_b), .frame_cnt(frame_cnt_b), .busy(busy_b)
  );

  spi_frame_timer #(.SCK_DIV(1), .FRAME_BITS(1), .IDLE_BITS(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .sck(sck_c), .ss_n(ss_n_c),
    .sck_lead(lead_c), .sck_trail(trail_c), .frame_start(fs_c), .frame_done(fd_c),
    .bit_idx(bit_idx_c), .frame_cnt(frame_cnt_c), .busy(busy_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic reset_a(input string p);
    chk({p, "_ss_n"}, ss_n_a, 1);
    chk({p, "_sck"}, sck_a, 0);
    chk({p, "_pulses"}, {lead_a, trail_a, fs_a, fd_a}, 0);
    chk({p, "_bit_idx"}, bit_idx_a, 15);
    chk({p, "_frame_cnt"}, frame_cnt_a, 0);
    chk({p, "_busy"}, busy_a, 0);
  endtask

  // Scoreboards: expectations pushed by the stimulus, popped when the DUT emits the event.
  int a_start_q[$];
  int a_cnt_q[$];
  int a_fs_cyc = 0, a_leads = 0, a_trails = 0, a_dones = 0, a_exp_bit = 15;
  logic a_bit_ok = 1'b1;

  always @(negedge clk) begin
    if (rst_a) begin
      a_leads  = 0;
      a_trails = 0;
    end else begin
      if (fs_a) begin
        chk("a_fs_expected", a_start_q.size() > 0, 1);
        if (a_start_q.size() > 0) chk("a_fs_cycle", cyc, a_start_q.pop_front());
        chk("a_fs_no_sck_edge", {lead_a, trail_a}, 0);
        chk("a_fs_bit_idx", bit_idx_a, 15);
        a_fs_cyc  = cyc;
        a_leads   = 0;
        a_trails  = 0;
        a_exp_bit = 15;
        a_bit_ok  = 1'b1;
      end
      if (lead_a) begin
        if (bit_idx_a !== 4'(a_exp_bit)) a_bit_ok = 1'b0;
        a_exp_bit--;
        a_leads++;
      end
      if (trail_a) a_trails++;
      if (fd_a) begin
        a_dones++;
        chk("a_ss_low_len", cyc - a_fs_cyc, 640);
        chk("a_lead_count", a_leads, 16);
        chk("a_trail_count", a_trails, 16);
        chk("a_fd_with_trail", trail_a, 1);
        chk("a_bit_seq", a_bit_ok, 1);
        chk("a_fd_bit_idx", bit_idx_a, 15);
        chk("a_fd_expected", a_cnt_q.size() > 0, 1);
        if (a_cnt_q.size() > 0) chk("a_frame_cnt", frame_cnt_a, a_cnt_q.pop_front());
      end
    end
  end

  int b_lead_q[$];
  int b_trail_q[$];
  int b_fs_cyc = 0, b_fd_cyc = 0, b_dones = 0;
  logic b_seen_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_b) begin
      if (fs_b) begin
        chk("b_fs_sck_idle", sck_b, 1);
        if (b_seen_done) chk("b_ss_high_len", cyc - b_fd_cyc, 12);
        b_fs_cyc = cyc;
      end
      if (lead_b) begin
        chk("b_lead_expected", b_lead_q.size() > 0, 1);
        if (b_lead_q.size() > 0) chk("b_lead_rel", cyc - b_fs_cyc, b_lead_q.pop_front());
        chk("b_lead_sck", sck_b, 0);
      end
      if (trail_b) begin
        chk("b_trail_expected", b_trail_q.size() > 0, 1);
        if (b_trail_q.size() > 0) chk("b_trail_rel", cyc - b_fs_cyc, b_trail_q.pop_front());
        chk("b_trail_sck", sck_b, 1);
      end
      if (fd_b) begin
        b_dones++;
        chk("b_ss_low_len", cyc - b_fs_cyc, 24);
        chk("b_fd_ss_n", ss_n_b, 1);
        chk("b_fd_bit_idx", bit_idx_b, 3);
        chk("b_fd_frame_cnt", frame_cnt_b, b_dones);
        b_fd_cyc    = cyc;
        b_seen_done = 1'b1;
      end
    end
  end

  int c_ss_q[$];
  int c_cnt_q[$];
  int c_e0 = 1 << 30;

  always @(negedge clk) begin
    if (!rst_c) begin
      if (cyc >= c_e0 && c_ss_q.size() > 0) chk("c_ss_pattern", ss_n_c, c_ss_q.pop_front());
      if (!ss_n_c && !fs_c) begin
        chk("c_one_edge", lead_c ^ trail_c, 1);
        chk("c_sck_high", sck_c, 1);
      end
      if (fd_c) begin
        chk("c_fd_with_trail", trail_c, 1);
        chk("c_fd_expected", c_cnt_q.size() > 0, 1);
        if (c_cnt_q.size() > 0) chk("c_frame_cnt", frame_cnt_c, c_cnt_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  initial begin
    int n;
    int e0;
    int fs;
    int d;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;
    repeat (5) @(negedge clk);

    reset_a("a_rst");
    chk("b_rst_sck", sck_b, 1);
    chk("b_rst_ss_bit", {ss_n_b, bit_idx_b, busy_b}, 4'b1110);
    chk("c_rst_state", {ss_n_c, sck_c, bit_idx_c, frame_cnt_c, busy_c}, 6'b100000);

    e0   = cyc + 1;
    c_e0 = e0;
    for (int i = 0; i < 3; i++) begin
      a_start_q.push_back(e0 + 640 + i * 1280);
      a_cnt_q.push_back(i + 1);
    end
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) begin
        b_lead_q.push_back(3 + 6 * i);
        b_trail_q.push_back(6 + 6 * i);
      end
    for (int f = 0; f < 5; f++) begin
      c_ss_q.push_back(1); c_ss_q.push_back(1);
      c_ss_q.push_back(0); c_ss_q.push_back(0);
      c_cnt_q.push_back((f + 1) % 4);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    @(negedge clk);
    chk("a_busy_at_e0", busy_a, 1);
    chk("a_ss_n_at_e0", ss_n_a, 1);
    chk("b_busy_at_e0", busy_b, 1);

    // C: five frames then stop; B: two frames then stop.
    wait_cyc(e0 + 19);
    en_c = 1'b0;
    wait_cyc(e0 + 60);
    en_b = 1'b0;
    wait_cyc(e0 + 90);
    chk("b_off_busy", busy_b, 0);
    chk("b_off_idle", {sck_b, ss_n_b}, 2'b11);
    chk("b_frames", b_dones, 2);
    chk("b_queues_drained", b_lead_q.size() + b_trail_q.size(), 0);
    chk("c_off_busy", busy_c, 0);
    chk("c_final_cnt", frame_cnt_c, 1);
    chk("c_queues_drained", c_ss_q.size() + c_cnt_q.size(), 0);

    // A: continuous run, then drop en at bit 5 of the third frame.
    n = 0;
    while (frame_cnt_a != 16'd2 && n < 4000) begin @(negedge clk); n++; end
    chk("a_wait_two_frames", frame_cnt_a, 2);
    @(negedge clk);
    n = 0;
    while (!fs_a && n < 2000) begin @(negedge clk); n++; end
    chk("a_wait_fs3", fs_a, 1);
    n = 0;
    while (!(bit_idx_a == 4'd5 && !ss_n_a) && n < 1000) begin @(negedge clk); n++; end
    chk("a_wait_bit5", bit_idx_a, 5);
    en_a = 1'b0;
    n = 0;
    while (!fd_a && n < 1000) begin @(negedge clk); n++; end
    chk("a_wait_fd3", fd_a, 1);
    chk("a_cnt_after_drop", frame_cnt_a, 3);
    d = cyc;
    wait_cyc(d + 639);
    chk("a_gap_still_busy", {busy_a, ss_n_a}, 2'b11);
    @(negedge clk);
    chk("a_off_busy", busy_a, 0);
    chk("a_off_idle", {sck_a, ss_n_a}, 2'b01);
    chk("a_off_frame_cnt", frame_cnt_a, 3);
    repeat (20) @(negedge clk);
    chk("a_no_more_frames", a_start_q.size() + a_cnt_q.size(), 0);
    chk("a_stays_off", busy_a, 0);

    // A: restart, then reset during half-period k=7.
    en_a = 1'b1;
    a_start_q.push_back(cyc + 1 + 640);
    @(negedge clk);
    n = 0;
    while (!fs_a && n < 1000) begin @(negedge clk); n++; end
    chk("a_wait_fs4", fs_a, 1);
    fs = cyc;
    wait_cyc(fs + 145);
    chk("a_k7_bit_idx", bit_idx_a, 12);
    chk("a_k7_sck", sck_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    reset_a("a_midrst");
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("a_post_rst_off", busy_a, 0);
    chk("a_done_count", a_dones, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
